// File: rtl/prach_buffer_readout_rr.sv
// PRACH buffer readout: round-robin grant over the channel buffers, segment-interleaved reads, FFT stream.
// Build option: PRACH_RDOUT_BITREV_EN selects bit-reversed in-segment addressing (natural order otherwise).
//
// state | meaning
// IDLE  | waiting for ap_req, arbitrating from the RR pointer
// READ  | one buffer read issued per cycle
// DRAIN | ack pulse, waiting for the RAM/output pipe to empty
module prach_buffer_readout_rr #(
  parameter int NUM_CH  = 24,
  parameter int HDR_W   = 120,
  parameter int DATA_W  = 32,
  parameter int SEG_AW  = 9,
  parameter int NUM_SEG = 3,
  parameter int RD_LAT  = 2,
  localparam int SG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int ADDR_W = SG_W + SEG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*HDR_W-1:0]   ap_hdr,
  input  logic [NUM_CH-1:0]         ap_req,
  output logic [NUM_CH-1:0]         ap_ack,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [NUM_CH-1:0]         rd_en,
  input  logic [NUM_CH*DATA_W-1:0]  rd_data,
  output logic [DATA_W/2-1:0]       dout_dr,
  output logic [DATA_W/2-1:0]       dout_di,
  output logic                      dout_dv,
  output logic                      sync_out,
  output logic [HDR_W-1:0]          hdr_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DC_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   nxt_grant;
  logic [SEG_AW-1:0] k;
  logic [SEG_AW-1:0] nk;
  logic [SG_W-1:0]   s;
  logic [SG_W-1:0]   ns;
  logic [DC_W-1:0]   drain_cnt;
  logic              rd_first;
  logic              last_issue;
  logic [RD_LAT:0]   iss_pipe;
  logic [RD_LAT:0]   sync_pipe;

  function automatic logic [ADDR_W-1:0] seg_addr(logic [SG_W-1:0] sv, logic [SEG_AW-1:0] kv);
`ifdef PRACH_RDOUT_BITREV_EN
    logic [SEG_AW-1:0] r;
    r = '0;
    for (int i = 0; i < SEG_AW; i++) r[i] = kv[SEG_AW-1-i];
    return {sv, r};
`else
    return {sv, kv};
`endif
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    nxt_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ap_req[idx]) begin
        found     = 1'b1;
        nxt_grant = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ns = s + 1'b1;
    nk = k;
    if (s == SG_W'(NUM_SEG - 1)) begin
      ns = '0;
      nk = k + 1'b1;
    end
  end

  assign last_issue = (k == '1) && (s == SG_W'(NUM_SEG - 1));
  assign dout_dv    = iss_pipe[RD_LAT];
  assign sync_out   = sync_pipe[RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      k         <= '0;
      s         <= '0;
      drain_cnt <= '0;
      rd_first  <= 1'b0;
      rd_addr   <= '0;
      rd_en     <= '0;
      ap_ack    <= '0;
      hdr_out   <= '0;
      dout_dr   <= '0;
      dout_di   <= '0;
      iss_pipe  <= '0;
      sync_pipe <= '0;
    end else begin
      ap_ack    <= '0;
      rd_first  <= 1'b0;
      iss_pipe  <= {iss_pipe[RD_LAT-1:0], |rd_en};
      sync_pipe <= {sync_pipe[RD_LAT-1:0], rd_first};
      // Capture the cycle the RAM data for an issue is valid; grant stays latched until the pipe is empty.
      if (iss_pipe[RD_LAT-1])
        {dout_di, dout_dr} <= rd_data[grant*DATA_W +: DATA_W];

      case (state)
        IDLE: begin
          if (|ap_req) begin
            grant    <= nxt_grant;
            hdr_out  <= ap_hdr[nxt_grant*HDR_W +: HDR_W];
            ptr      <= (nxt_grant == CH_W'(NUM_CH - 1)) ? '0 : nxt_grant + 1'b1;
            k        <= '0;
            s        <= '0;
            rd_addr  <= seg_addr('0, '0);
            rd_en    <= NUM_CH'(1) << nxt_grant;
            rd_first <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (last_issue) begin
            ap_ack    <= rd_en;
            rd_en     <= '0;
            rd_addr   <= '0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            k       <= nk;
            s       <= ns;
            rd_addr <= seg_addr(ns, nk);
          end
        end
        DRAIN: begin
          if (drain_cnt == DC_W'(RD_LAT)) state <= IDLE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prach_buffer_readout_rr.sv
// Scoreboard bench for prach_buffer_readout_rr: RAM model, expected-grant and expected-sample queues.
module tb_prach_buffer_readout_rr;
  localparam int NUM_CH = 24, HDR_W = 120, DATA_W = 32, SEG_AW = 9, NUM_SEG = 3, RD_LAT = 2;
  localparam int ADDR_W = 11;
  localparam int TOTAL  = NUM_SEG * (1 << SEG_AW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH*HDR_W-1:0]  ap_hdr;
  logic [NUM_CH-1:0]        ap_req = '0;
  logic [NUM_CH-1:0]        ap_ack;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_CH-1:0]        rd_en;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [DATA_W/2-1:0]      dout_dr, dout_di;
  logic                     dout_dv, sync_out;
  logic [HDR_W-1:0]         hdr_out;

  prach_buffer_readout_rr #(
    .NUM_CH(NUM_CH), .HDR_W(HDR_W), .DATA_W(DATA_W),
    .SEG_AW(SEG_AW), .NUM_SEG(NUM_SEG), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .ap_hdr(ap_hdr), .ap_req(ap_req), .ap_ack(ap_ack),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
    .sync_out(sync_out), .hdr_out(hdr_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [HDR_W-1:0] hdr_pat(int ch);
    return {8'(ch), 8'hE5, 104'(64'h0123_4567_89AB_CDEF ^ 64'(ch * 32'h0101_0101))};
  endfunction

  function automatic logic [DATA_W-1:0] pat(int ch, logic [ADDR_W-1:0] a);
    return {8'(ch + 1), 8'h5A ^ a[7:0], 16'(a)};
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(int n);
    logic [SEG_AW-1:0] kk, r;
    int s;
    kk = SEG_AW'(n / NUM_SEG);
    s  = n % NUM_SEG;
`ifdef PRACH_RDOUT_BITREV_EN
    for (int i = 0; i < SEG_AW; i++) r[i] = kk[SEG_AW-1-i];
`else
    r = kk;
`endif
    return ADDR_W'((s << SEG_AW) | int'(r));
  endfunction

  always_comb begin
    ap_hdr = '0;
    for (int c = 0; c < NUM_CH; c++) ap_hdr[c*HDR_W +: HDR_W] = hdr_pat(c);
  end

  // Buffer RAM model: read data RD_LAT cycles after rd_en, zero for a channel not enabled.
  logic [ADDR_W-1:0] addr_d [RD_LAT];
  logic [NUM_CH-1:0] en_d   [RD_LAT];
  always @(posedge clk) begin
    addr_d[0] <= rd_addr;
    en_d[0]   <= rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_d[i] <= addr_d[i-1];
      en_d[i]   <= en_d[i-1];
    end
  end
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      rd_data[c*DATA_W +: DATA_W] = en_d[RD_LAT-1][c] ? pat(c, addr_d[RD_LAT-1]) : '0;
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    int                ch;
    int                stamp;
  } sb_t;

  sb_t sb[$];
  int  grant_q[$];
  int  npass = 0, nchk = 0;
  int  mon_n = 0, cur_ch = 0, last_iss = -100;
  int  dv_cnt = 0, sync_cnt = 0;
  bit  chk_gap = 0, done = 0;
  logic [DATA_W-1:0] last_dout = '0;
  logic [ADDR_W-1:0] addr_log [5];

  task automatic monitor();
    logic [ADDR_W-1:0] a;
    logic [NUM_CH-1:0] exp_ack;
    sb_t e;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        mon_n = 0;
        last_iss = -100;
        last_dout = '0;
        continue;
      end
      if (rd_en != 0) begin
        if (mon_n == 0) begin
          nchk++;
          if (grant_q.size() == 0) $display("FAIL unexpected_readout: rd_en %h, no grant expected", rd_en);
          else begin cur_ch = grant_q.pop_front(); npass++; end
          if (chk_gap && last_iss >= 0) begin
            nchk++;
            if (cyc - last_iss !== RD_LAT + 3) $display("FAIL readout_gap: got %0d, expected %0d", cyc - last_iss, RD_LAT + 3);
            else npass++;
          end
        end
        a = model_addr(mon_n);
        nchk++;
        if (rd_en !== (NUM_CH'(1) << cur_ch)) $display("FAIL rd_en_onehot: got %h, expected ch %0d", rd_en, cur_ch);
        else npass++;
        nchk++;
        if (rd_addr !== a) $display("FAIL rd_addr[%0d]: got %h, expected %h", mon_n, rd_addr, a);
        else npass++;
        if (mon_n < 5) addr_log[mon_n] = rd_addr;
        sb.push_back('{data: pat(cur_ch, a), first: (mon_n == 0), ch: cur_ch, stamp: cyc});
        if (mon_n == TOTAL - 1) begin mon_n = 0; last_iss = cyc; end
        else mon_n++;
      end else begin
        nchk++;
        if (rd_addr !== '0) $display("FAIL rd_addr_idle: got %h, expected 0", rd_addr);
        else npass++;
      end
      exp_ack = (cyc == last_iss + 1) ? (NUM_CH'(1) << cur_ch) : '0;
      if (ap_ack != 0 || exp_ack != 0) begin
        nchk++;
        if (ap_ack !== exp_ack) $display("FAIL ap_ack: got %h, expected %h", ap_ack, exp_ack);
        else npass++;
      end
      if (dout_dv) begin
        nchk++;
        if (sb.size() == 0) $display("FAIL spurious_dv: got dout %h, expected no sample", {dout_di, dout_dr});
        else begin
          npass++;
          e = sb.pop_front();
          nchk++;
          if ({dout_di, dout_dr} !== e.data) $display("FAIL dout_data: got %h, expected %h", {dout_di, dout_dr}, e.data);
          else npass++;
          nchk++;
          if (sync_out !== e.first) $display("FAIL sync_out: got %b, expected %b", sync_out, e.first);
          else npass++;
          nchk++;
          if (cyc !== e.stamp + RD_LAT + 1) $display("FAIL dv_latency: got %0d, expected %0d", cyc - e.stamp, RD_LAT + 1);
          else npass++;
          if (e.first) begin
            nchk++;
            if (hdr_out !== hdr_pat(e.ch)) $display("FAIL hdr_out: got %h, expected %h", hdr_out, hdr_pat(e.ch));
            else npass++;
          end
          last_dout = e.data;
        end
        dv_cnt++;
        if (sync_out) sync_cnt++;
      end else begin
        nchk++;
        if ({dout_di, dout_dr} !== last_dout || sync_out !== 1'b0)
          $display("FAIL dout_hold: got %h sync %b, expected %h sync 0", {dout_di, dout_dr}, sync_out, last_dout);
        else npass++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output logic [NUM_CH-1:0] a, output bit ok);
    ok = 0;
    a  = '0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (ap_ack != 0) begin ok = 1; a = ap_ack; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nchk += 7;
    if (rd_en !== '0)    $display("FAIL rst_rd_en: got %h, expected 0", rd_en);     else npass++;
    if (rd_addr !== '0)  $display("FAIL rst_rd_addr: got %h, expected 0", rd_addr); else npass++;
    if (ap_ack !== '0)   $display("FAIL rst_ap_ack: got %h, expected 0", ap_ack);   else npass++;
    if (dout_dv !== 0)   $display("FAIL rst_dout_dv: got %b, expected 0", dout_dv); else npass++;
    if (sync_out !== 0)  $display("FAIL rst_sync: got %b, expected 0", sync_out);   else npass++;
    if ({dout_di, dout_dr} !== '0) $display("FAIL rst_dout: got %h, expected 0", {dout_di, dout_dr}); else npass++;
    if (hdr_out !== '0)  $display("FAIL rst_hdr: got %h, expected 0", hdr_out);     else npass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NUM_CH-1:0] a;
    bit ok;
    logic [ADDR_W-1:0] exp5 [5];
`ifdef PRACH_RDOUT_BITREV_EN
    exp5 = '{11'h000, 11'h200, 11'h400, 11'h100, 11'h300};
`else
    exp5 = '{11'h000, 11'h200, 11'h400, 11'h001, 11'h201};
`endif
    dv_cnt = 0;
    sync_cnt = 0;
    grant_q.push_back(0);
    ap_req[0] = 1'b1;
    wait_ack(a, ok);
    ap_req[0] = 1'b0;
    nchk++;
    if (!ok || a !== 24'h1) $display("FAIL single_ack: got %h (seen %0d), expected 000001", a, ok);
    else npass++;
    repeat (RD_LAT + 2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if (addr_log[i] !== exp5[i]) $display("FAIL first_addr[%0d]: got %h, expected %h", i, addr_log[i], exp5[i]);
      else npass++;
    end
    nchk += 3;
    if (dv_cnt !== TOTAL) $display("FAIL single_dv_count: got %0d, expected %0d", dv_cnt, TOTAL); else npass++;
    if (sync_cnt !== 1)   $display("FAIL single_sync_count: got %0d, expected 1", sync_cnt);    else npass++;
    if (sb.size() !== 0)  $display("FAIL single_sb_left: got %0d, expected 0", sb.size());      else npass++;
  endtask

  task automatic test_rst_mid();
    logic [NUM_CH-1:0] a;
    bit ok;
    int guard;
    do_reset();
    grant_q.push_back(0);
    ap_req[0] = 1'b1;
    guard = 0;
    while (mon_n < 700 && guard < 3000) begin @(negedge clk); guard++; end
    nchk++;
    if (mon_n < 700) $display("FAIL rst_mid_reach: got %0d reads, expected 700", mon_n); else npass++;
    rst = 1'b1;
    #1;
    nchk += 4;
    if (rd_en !== '0 || rd_addr !== '0) $display("FAIL rst_mid_rd: got en %h addr %h, expected 0", rd_en, rd_addr); else npass++;
    if (ap_ack !== '0) $display("FAIL rst_mid_ack: got %h, expected 0", ap_ack); else npass++;
    if (dout_dv !== 0 || sync_out !== 0) $display("FAIL rst_mid_dv: got %b/%b, expected 0", dout_dv, sync_out); else npass++;
    if ({dout_di, dout_dr} !== '0 || hdr_out !== '0) $display("FAIL rst_mid_data: got %h, expected 0", {dout_di, dout_dr}); else npass++;
    grant_q.delete();
    grant_q.push_back(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dv_cnt = 0;
    wait_ack(a, ok);
    ap_req[0] = 1'b0;
    nchk++;
    if (!ok || a !== 24'h1) $display("FAIL rst_mid_ack_after: got %h (seen %0d), expected 000001", a, ok);
    else npass++;
    repeat (RD_LAT + 2) @(negedge clk);
    nchk++;
    if (dv_cnt !== TOTAL) $display("FAIL rst_mid_dv_count: got %0d, expected %0d", dv_cnt, TOTAL); else npass++;
  endtask

  task automatic test_rr_pair();
    logic [NUM_CH-1:0] a;
    bit ok;
    grant_q.push_back(3);
    ap_req[3] = 1'b1;
    wait_ack(a, ok);
    ap_req[3] = 1'b0;
    nchk++;
    if (!ok || a !== (NUM_CH'(1) << 3)) $display("FAIL rr_prep_ack: got %h, expected ch3", a); else npass++;
    repeat (RD_LAT + 3) @(negedge clk);
    grant_q.push_back(5);
    grant_q.push_back(3);
    ap_req[3] = 1'b1;
    ap_req[5] = 1'b1;
    wait_ack(a, ok);
    ap_req[5] = 1'b0;
    nchk++;
    if (!ok || a !== (NUM_CH'(1) << 5)) $display("FAIL rr_first_ch5: got %h, expected ch5", a); else npass++;
    wait_ack(a, ok);
    ap_req[3] = 1'b0;
    nchk++;
    if (!ok || a !== (NUM_CH'(1) << 3)) $display("FAIL rr_second_ch3: got %h, expected ch3", a); else npass++;
    repeat (RD_LAT + 3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] a;
    bit ok;
    int ch;
    do_reset();
    for (int i = 0; i <= NUM_CH; i++) grant_q.push_back(i % NUM_CH);
    chk_gap = 1;
    ap_req = '1;
    for (int i = 0; i <= NUM_CH; i++) begin
      ch = i % NUM_CH;
      wait_ack(a, ok);
      if (i == NUM_CH) ap_req = '0;
      nchk++;
      if (!ok || a !== (NUM_CH'(1) << ch)) $display("FAIL b2b_ack[%0d]: got %h, expected ch%0d", i, a, ch);
      else npass++;
      if (!ok) begin
        ap_req = '0;
        break;
      end
    end
    repeat (RD_LAT + 3) @(negedge clk);
    chk_gap = 0;
    nchk++;
    if (grant_q.size() !== 0 || sb.size() !== 0)
      $display("FAIL b2b_leftover: got grants %0d samples %0d, expected 0", grant_q.size(), sb.size());
    else npass++;
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_rst_mid();
        test_rr_pair();
        test_back_to_back();
        done = 1;
      end
      monitor();
    join
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
